led_blink_sched: RTL and testbench

//  Round-robin scheduler that shares the board status LED among NUM_REQ requesters.

---
 rtl/led_ctrl_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/led_blink_sched.sv | 147 ++++++++++++++
 tb/tb_led_blink_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED blink scheduler: FSM state encoding,
// default parameter values and the phase-counter width helper.
package led_ctrl_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_CNT_W        = 4;
  localparam int DEF_PHASE_CYCLES = 5;
  localparam int DEF_GAP_CYCLES   = 10;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_ON   = 2'd1;
  localparam logic [1:0] ENC_OFF  = 2'd2;
  localparam logic [1:0] ENC_GAP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_ON   = ENC_ON,
    ST_OFF  = ENC_OFF,
    ST_GAP  = ENC_GAP
  } state_e;

  // Wide enough to hold the longest phase length without wrapping.
  function automatic int phase_cnt_width(input int phase_cycles, input int gap_cycles);
    return $clog2(((phase_cycles > gap_cycles) ? phase_cycles : gap_cycles) + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request found
// scanning upward from last+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/led_blink_sched.sv
// Round-robin scheduler sharing one status LED among NUM_REQ requesters; each
// grant plays blink_cnt ON/OFF pairs followed by a fixed low gap, then pulses done.
module led_blink_sched
  import led_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] blink_cnt,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     done,
  output logic                     led
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PH_W  = phase_cnt_width(PHASE_CYCLES, GAP_CYCLES);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASE_CYCLES - 1);
  localparam logic [PH_W-1:0]  GAP_LAST = PH_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               led_q, led_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [CNT_W-1:0]   cnt_arr [NUM_REQ];
  logic [CNT_W-1:0]   sel_cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign cnt_arr[g] = blink_cnt[g*CNT_W +: CNT_W];
  end
  assign sel_cnt = cnt_arr[arb_idx];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req  (req),
    .last (last_q),
    .en   (state_q == ST_IDLE),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    rem_d   = rem_q;
    last_d  = last_q;
    grant_d = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    led_d   = led_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          rem_d   = sel_cnt;
          last_d  = arb_idx;
          grant_d = arb_gnt;
          busy_d  = 1'b1;
          ph_d    = '0;
          // A zero-length burst skips straight to the gap.
          if (sel_cnt != '0) begin
            state_d = ST_ON;
            led_d   = 1'b1;
          end else begin
            state_d = ST_GAP;
            led_d   = 1'b0;
          end
        end
      end
      ST_ON: begin
        if (ph_q == PH_LAST) begin
          state_d = ST_OFF;
          led_d   = 1'b0;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_OFF: begin
        if (ph_q == PH_LAST) begin
          rem_d = rem_q - 1'b1;
          ph_d  = '0;
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_ON;
            led_d   = 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (ph_q == GAP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: rem needs no reset value functionally, but resetting it keeps the register free of X in simulation.
      state_q <= ST_IDLE;
      ph_q    <= '0;
      rem_q   <= '0;
      last_q  <= LAST_RST;
      grant_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Scoreboard bench for led_blink_sched: a transaction-level model predicts each
// grant and its burst waveform; a negedge monitor compares DUT outputs every cycle.
module tb_led_blink_sched;
  import led_ctrl_pkg::*;

  localparam int NR = DEF_NUM_REQ;
  localparam int CW = DEF_CNT_W;
  localparam int P  = DEF_PHASE_CYCLES;
  localparam int G  = DEF_GAP_CYCLES;

  typedef struct {
    int g;
    int idx;
    int cnt;
  } txn_t;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*CW-1:0] blink_cnt;
  logic [NR-1:0] grant;
  logic          busy;
  logic          done;
  logic          led;

  led_blink_sched #(.NUM_REQ(NR), .CNT_W(CW), .PHASE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .blink_cnt (blink_cnt),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_err = 0;
  txn_t exp_q[$];
  bit   kill_cyc[int];

  task automatic check(input string name, input int c, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  // Monitor: derives the expected outputs of the current cycle from the scoreboard.
  txn_t cur;
  bit   cur_valid = 1'b0;
  int   k, len, e_grant, e_busy, e_done, e_led;
  always @(negedge clk) begin
    if (cyc >= 2) begin
      e_grant = 0;
      if (exp_q.size() > 0 && exp_q[0].g == cyc) begin
        cur       = exp_q.pop_front();
        cur_valid = 1'b1;
        e_grant   = 1 << cur.idx;
      end
      if (kill_cyc.exists(cyc)) cur_valid = 1'b0;
      e_busy = 0;
      e_done = 0;
      e_led  = 0;
      if (cur_valid) begin
        k   = cyc - cur.g;
        len = 2 * P * cur.cnt + G;
        if (k < len) begin
          e_busy = 1;
          e_led  = (k < 2 * P * cur.cnt && (k / P) % 2 == 0) ? 1 : 0;
        end else if (k == len) begin
          e_done = 1;
        end else begin
          cur_valid = 1'b0;
        end
      end
      check("grant", cyc, int'(grant), e_grant);
      check("busy",  cyc, int'(busy),  e_busy);
      check("done",  cyc, int'(done),  e_done);
      check("led",   cyc, int'(led),   e_led);
    end
  end

  // Reference model state: round-robin pointer and first cycle the block is idle again.
  int      m_last = NR - 1;
  int      m_idle_from = 1 << 30;
  bit [NR-1:0] pend = '0;
  bit      hold_all = 1'b0;

  task automatic set_cnt(input int i, input int v);
    blink_cnt[i*CW +: CW] = CW'(v);
  endtask

  // Applies the current inputs for one cycle, updates the model, and advances to the next negedge.
  task automatic run_cycles(input int n, input bit rnd);
    for (int s = 0; s < n; s++) begin
      int   now = cyc;
      txn_t t;
      if (rnd) begin
        for (int i = 0; i < NR; i++) begin
          if (!pend[i] && $urandom_range(0, 7) == 0) pend[i] = 1'b1;
          else if (pend[i] && $urandom_range(0, 63) == 0) pend[i] = 1'b0;
          if ($urandom_range(0, 3) == 0)
            set_cnt(i, ($urandom_range(0, 15) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3));
        end
        rst = ($urandom_range(0, 499) == 0);
      end
      req = hold_all ? '1 : pend;
      if (rst) begin
        kill_cyc[now + 1] = 1'b1;
        m_last      = NR - 1;
        m_idle_from = now + 1;
      end else if (now >= m_idle_from && |req) begin
        for (int i = 1; i <= NR; i++) begin
          int c = (m_last + i) % NR;
          if (req[c]) begin
            t.g   = now + 1;
            t.idx = c;
            t.cnt = int'(blink_cnt[c*CW +: CW]);
            exp_q.push_back(t);
            m_last      = c;
            m_idle_from = t.g + 2 * P * t.cnt + G;
            pend[c]     = 1'b0;
            break;
          end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    blink_cnt = '0;
    @(negedge clk);

    // Reset held with every request asserted.
    pend = '1;
    run_cycles(2, 1'b0);
    rst  = 1'b0;
    pend = '0;
    run_cycles(3, 1'b0);

    // Single requester, three blinks.
    set_cnt(1, 3);
    pend = 4'b0010;
    run_cycles(50, 1'b0);

    // All requesters held continuously, one blink each.
    for (int i = 0; i < NR; i++) set_cnt(i, 1);
    hold_all = 1'b1;
    run_cycles(110, 1'b0);
    hold_all = 1'b0;
    run_cycles(25, 1'b0);

    // Zero-length burst.
    set_cnt(2, 0);
    pend = 4'b0100;
    run_cycles(15, 1'b0);

    // Reset in the middle of a burst, then pointer restart.
    set_cnt(3, 2);
    pend = 4'b1000;
    run_cycles(4, 1'b0);
    rst = 1'b1;
    run_cycles(1, 1'b0);
    rst = 1'b0;
    set_cnt(0, 1);
    set_cnt(2, 1);
    pend = 4'b0101;
    run_cycles(50, 1'b0);
    pend = '0;
    run_cycles(5, 1'b0);

    // Request pulsed while another burst is active is dropped.
    set_cnt(0, 2);
    pend = 4'b0001;
    run_cycles(3, 1'b0);
    pend[1] = 1'b1;
    run_cycles(4, 1'b0);
    pend[1] = 1'b0;
    run_cycles(40, 1'b0);

    // Randomized traffic, including occasional resets.
    run_cycles(4000, 1'b1);

    rst  = 1'b0;
    pend = '0;
    run_cycles(200, 1'b0);
    check("queue_drain", cyc, exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
